// File: rtl/pad_attr_seq.sv
// pad_attr_seq: sequenced pad-attribute update engine.
//
// Takes one attribute-update request at a time. The requested value is ANDed
// with the target pad's WARL mask. The result is written to that pad's
// attribute register only while the pad's output enable is forced off. The
// OE force is held for SettleCycles cycles before the write and
// SettleCycles cycles after it.
//
// Ports:
//   clk_i, rst_ni   clock and asynchronous active-low reset
//   req_i           level request, held until ack_o
//   idx_i, attr_i   target pad and requested attribute, valid with req_i
//   warl_i          per-pad supported-attribute mask, static after reset
//   ack_o, err_o    one-cycle completion strobe; err_o flags an out-of-range index
//   busy_o          high whenever the sequencer is not idle
//   attr_o          applied attributes (registered)
//   oe_gate_o       per-pad output-disable force (registered)

package pad_attr_pkg;
    typedef struct packed {
        logic [1:0] slew_rate;
        logic [3:0] drive_strength;
        logic       od_en;
        logic       schmitt_en;
        logic       keep_en;
        logic       pull_select;
        logic       pull_en;
        logic       virt_od_en;
        logic       invert;
    } pad_attr_t;
endpackage

module pad_attr_seq
    import pad_attr_pkg::*;
#(
    parameter int NumPads      = 16,
    parameter int SettleCycles = 2
) (
    input  logic                                               clk_i,
    input  logic                                               rst_ni,
    input  logic                                               req_i,
    input  logic [((NumPads > 1) ? $clog2(NumPads) : 1)-1:0]   idx_i,
    input  pad_attr_t                                          attr_i,
    input  pad_attr_t                                          warl_i [NumPads],
    output logic                                               ack_o,
    output logic                                               err_o,
    output logic                                               busy_o,
    output pad_attr_t                                          attr_o [NumPads],
    output logic [NumPads-1:0]                                 oe_gate_o
);

    localparam int IdxW = (NumPads > 1) ? $clog2(NumPads) : 1;
    localparam int CntW = $clog2(SettleCycles + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(SettleCycles - 1);

    typedef enum logic [2:0] {
        StIdle,
        StGate,
        StApply,
        StRelease,
        StAck
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    pad_attr_t           val_q, val_d;
    logic                err_q, err_d;
    pad_attr_t           attr_q [NumPads];
    pad_attr_t           attr_d [NumPads];
    logic [NumPads-1:0]  gate_q, gate_d;

    logic                in_range;
    pad_attr_t           masked;

    assign in_range = 32'(idx_i) < 32'(NumPads);
    assign masked   = in_range ? (attr_i & warl_i[idx_i]) : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        val_d   = val_q;
        err_d   = err_q;
        attr_d  = attr_q;
        gate_d  = '0;

        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    idx_d = idx_i;
                    val_d = masked;
                    err_d = !in_range;
                    if (!in_range) begin
                        state_d = StAck;
                    end else if (masked == attr_q[idx_i]) begin
                        state_d = StAck;
                    end else begin
                        state_d = StGate;
                        cnt_d   = CntLoad;
                    end
                end
            end
            StGate: begin
                if (cnt_q == '0) begin
                    state_d = StApply;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StApply: begin
                attr_d[idx_q] = val_q;
                state_d       = StRelease;
                cnt_d         = CntLoad;
            end
            StRelease: begin
                if (cnt_q == '0) begin
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StAck: begin
                state_d = StIdle;
                err_d   = 1'b0;
            end
            default: state_d = StIdle;
        endcase

        // The gate register follows the next state, so the force appears in
        // the first Gate cycle and drops together with entry into Ack.
        if (state_d == StGate || state_d == StApply || state_d == StRelease) begin
            gate_d[idx_d] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            val_q   <= '0;
            err_q   <= 1'b0;
            gate_q  <= '0;
            for (int unsigned i = 0; i < NumPads; i++) begin
                attr_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
            err_q   <= err_d;
            gate_q  <= gate_d;
            attr_q  <= attr_d;
        end
    end

    assign ack_o     = (state_q == StAck);
    assign err_o     = (state_q == StAck) && err_q;
    assign busy_o    = (state_q != StIdle);
    assign attr_o    = attr_q;
    assign oe_gate_o = gate_q;

endmodule

// File: tb/tb_pad_attr_seq.sv
// Directed bench for pad_attr_seq. Instance A: 16 pads, settle of 2 cycles.
// Instance B: 12 pads, settle of 4 cycles.
// In the comments below, cycle k means the period that starts at the k-th
// rising edge after acceptance, with acceptance at cycle 0.

module tb_pad_attr_seq;
    import pad_attr_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Instance A
    logic          rst_a_n, req_a, ack_a, err_a, busy_a;
    logic [3:0]    idx_a;
    pad_attr_t     attr_in_a;
    pad_attr_t     warl_a [16];
    pad_attr_t     attr_a [16];
    logic [15:0]   gate_a;

    // Instance B
    logic          rst_b_n, req_b, ack_b, err_b, busy_b;
    logic [3:0]    idx_b;
    pad_attr_t     attr_in_b;
    pad_attr_t     warl_b [12];
    pad_attr_t     attr_b [12];
    logic [11:0]   gate_b;

    pad_attr_seq #(.NumPads(16), .SettleCycles(2)) dut_a (
        .clk_i(clk), .rst_ni(rst_a_n), .req_i(req_a), .idx_i(idx_a),
        .attr_i(attr_in_a), .warl_i(warl_a), .ack_o(ack_a), .err_o(err_a),
        .busy_o(busy_a), .attr_o(attr_a), .oe_gate_o(gate_a)
    );

    pad_attr_seq #(.NumPads(12), .SettleCycles(4)) dut_b (
        .clk_i(clk), .rst_ni(rst_b_n), .req_i(req_b), .idx_i(idx_b),
        .attr_i(attr_in_b), .warl_i(warl_b), .ack_o(ack_b), .err_o(err_b),
        .busy_o(busy_b), .attr_o(attr_b), .oe_gate_o(gate_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        tick();
        tick();
        total_cnt++;
        if ({ack_a, err_a, busy_a, gate_a} !== 19'h0)
            $display("FAIL reset_a_ctrl got ack=%b err=%b busy=%b gate=%h want 0", ack_a, err_a, busy_a, gate_a);
        else pass_cnt++;
        total_cnt++;
        if ({ack_b, err_b, busy_b, gate_b} !== 15'h0)
            $display("FAIL reset_b_ctrl got ack=%b err=%b busy=%b gate=%h want 0", ack_b, err_b, busy_b, gate_b);
        else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            total_cnt++;
            if (attr_a[i] !== 13'h0) $display("FAIL reset_attr_a[%0d] got %h want 0", i, attr_a[i]);
            else pass_cnt++;
        end
        #3;
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        tick();
    endtask

    // idx=3, invert requested, warl[3]={invert,virt_od_en}; S=2.
    task automatic test_basic();
        pad_attr_t exp_attr;
        logic [15:0] exp_gate;
        exp_attr = '0;
        exp_attr.invert = 1'b1;
        attr_in_a = '0;
        attr_in_a.invert = 1'b1;
        idx_a = 4'd3;
        req_a = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_gate = (k >= 1 && k <= 5) ? 16'h0008 : 16'h0000;
            total_cnt++;
            if (gate_a !== exp_gate) $display("FAIL basic_gate c%0d got %h want %h", k, gate_a, exp_gate);
            else pass_cnt++;
            total_cnt++;
            if (attr_a[3] !== ((k >= 4) ? exp_attr : 13'h0))
                $display("FAIL basic_attr3 c%0d got %h want %h", k, attr_a[3], (k >= 4) ? exp_attr : 13'h0);
            else pass_cnt++;
            total_cnt++;
            if (ack_a !== (k == 6)) $display("FAIL basic_ack c%0d got %b want %b", k, ack_a, (k == 6));
            else pass_cnt++;
            total_cnt++;
            if (busy_a !== (k <= 6)) $display("FAIL basic_busy c%0d got %b want %b", k, busy_a, (k <= 6));
            else pass_cnt++;
            if (k == 6) begin
                total_cnt++;
                if (err_a !== 1'b0) $display("FAIL basic_err got %b want 0", err_a);
                else pass_cnt++;
                req_a = 1'b0;
            end
        end
        for (int i = 0; i < 16; i++) begin
            if (i != 3) begin
                total_cnt++;
                if (attr_a[i] !== 13'h0) $display("FAIL basic_other[%0d] got %h want 0", i, attr_a[i]);
                else pass_cnt++;
            end
        end
    endtask

    // Pad 5 supports only invert, so virt_od_en masks down to the current value.
    task automatic test_warl_mask();
        attr_in_a = '0;
        attr_in_a.virt_od_en = 1'b1;
        idx_a = 4'd5;
        req_a = 1'b1;
        tick();
        total_cnt++;
        if ({ack_a, err_a} !== 2'b10) $display("FAIL warl_ack got ack=%b err=%b want 1/0", ack_a, err_a);
        else pass_cnt++;
        total_cnt++;
        if (gate_a !== 16'h0) $display("FAIL warl_gate got %h want 0", gate_a);
        else pass_cnt++;
        req_a = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            tick();
            total_cnt++;
            if ({ack_a, busy_a, gate_a} !== 18'h0)
                $display("FAIL warl_idle c%0d got ack=%b busy=%b gate=%h want 0", k, ack_a, busy_a, gate_a);
            else pass_cnt++;
        end
        total_cnt++;
        if (attr_a[5] !== 13'h0) $display("FAIL warl_attr5 got %h want 0", attr_a[5]);
        else pass_cnt++;
    endtask

    task automatic test_out_of_range();
        attr_in_b = '1;
        idx_b = 4'd13;
        req_b = 1'b1;
        tick();
        total_cnt++;
        if ({ack_b, err_b} !== 2'b11) $display("FAIL oor_ack got ack=%b err=%b want 1/1", ack_b, err_b);
        else pass_cnt++;
        total_cnt++;
        if (gate_b !== 12'h0) $display("FAIL oor_gate got %h want 0", gate_b);
        else pass_cnt++;
        req_b = 1'b0;
        tick();
        total_cnt++;
        if ({ack_b, err_b, busy_b} !== 3'b000) $display("FAIL oor_after got ack=%b err=%b busy=%b want 0", ack_b, err_b, busy_b);
        else pass_cnt++;
        for (int i = 0; i < 12; i++) begin
            total_cnt++;
            if (attr_b[i] !== 13'h0) $display("FAIL oor_attr[%0d] got %h want 0", i, attr_b[i]);
            else pass_cnt++;
        end
    endtask

    // First: idx=7 pull_en. Inputs are disturbed mid-operation. Second request
    // (idx=9, drive_strength=A) is presented during Ack and accepted at cycle 7.
    task automatic test_back_to_back();
        pad_attr_t exp7, exp9;
        logic [15:0] exp_gate;
        exp7 = '0;
        exp7.pull_en = 1'b1;
        exp9 = '0;
        exp9.drive_strength = 4'hA;
        attr_in_a = exp7;
        idx_a = 4'd7;
        req_a = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k >= 1 && k <= 5) exp_gate = 16'h0080;
            else if (k >= 8 && k <= 12) exp_gate = 16'h0200;
            else exp_gate = 16'h0000;
            total_cnt++;
            if (gate_a !== exp_gate) $display("FAIL b2b_gate c%0d got %h want %h", k, gate_a, exp_gate);
            else pass_cnt++;
            total_cnt++;
            if (ack_a !== (k == 6 || k == 13)) $display("FAIL b2b_ack c%0d got %b want %b", k, ack_a, (k == 6 || k == 13));
            else pass_cnt++;
            total_cnt++;
            if (busy_a !== (k != 7 && k != 14)) $display("FAIL b2b_busy c%0d got %b want %b", k, busy_a, (k != 7 && k != 14));
            else pass_cnt++;
            case (k)
                1: begin idx_a = 4'd9; attr_in_a = '1; end
                2: req_a = 1'b0;
                3: req_a = 1'b1;
                6: begin idx_a = 4'd9; attr_in_a = exp9; req_a = 1'b1; end
                13: req_a = 1'b0;
                default: ;
            endcase
        end
        total_cnt++;
        if (attr_a[7] !== exp7) $display("FAIL b2b_attr7 got %h want %h", attr_a[7], exp7);
        else pass_cnt++;
        total_cnt++;
        if (attr_a[9] !== exp9) $display("FAIL b2b_attr9 got %h want %h", attr_a[9], exp9);
        else pass_cnt++;
        total_cnt++;
        if (attr_a[8] !== 13'h0) $display("FAIL b2b_attr8 got %h want 0", attr_a[8]);
        else pass_cnt++;
    endtask

    // S=4: gate during cycles 1..9, attr visible from 6, Release during 6..9.
    // Reset is asserted during cycle 7.
    task automatic test_reset_mid_release();
        pad_attr_t exp2, exp4;
        exp2 = '0;
        exp2.od_en = 1'b1;
        exp4 = '0;
        exp4.invert = 1'b1;
        attr_in_b = exp2;
        idx_b = 4'd2;
        req_b = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            total_cnt++;
            if (gate_b !== 12'h004) $display("FAIL rst_gate c%0d got %h want 004", k, gate_b);
            else pass_cnt++;
        end
        total_cnt++;
        if (attr_b[2] !== exp2) $display("FAIL rst_pre_attr2 got %h want %h", attr_b[2], exp2);
        else pass_cnt++;
        #2;
        rst_b_n = 1'b0;
        #1;
        total_cnt++;
        if (attr_b[2] !== 13'h0) $display("FAIL rst_async_attr2 got %h want 0", attr_b[2]);
        else pass_cnt++;
        total_cnt++;
        if ({gate_b, ack_b, busy_b} !== 14'h0) $display("FAIL rst_async_ctrl got gate=%h ack=%b busy=%b want 0", gate_b, ack_b, busy_b);
        else pass_cnt++;
        req_b = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            total_cnt++;
            if (ack_b !== 1'b0) $display("FAIL rst_hold_ack got %b want 0", ack_b);
            else pass_cnt++;
        end
        #3;
        rst_b_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total_cnt++;
            if ({ack_b, busy_b} !== 2'b00) $display("FAIL rst_after_idle got ack=%b busy=%b want 0", ack_b, busy_b);
            else pass_cnt++;
        end
        attr_in_b = exp4;
        idx_b = 4'd4;
        req_b = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            total_cnt++;
            if (gate_b !== ((k <= 9) ? 12'h010 : 12'h000)) $display("FAIL rst_new_gate c%0d got %h", k, gate_b);
            else pass_cnt++;
            if (k == 10) begin
                total_cnt++;
                if ({ack_b, err_b} !== 2'b10) $display("FAIL rst_new_ack got ack=%b err=%b want 1/0", ack_b, err_b);
                else pass_cnt++;
                req_b = 1'b0;
            end
        end
        total_cnt++;
        if (attr_b[4] !== exp4) $display("FAIL rst_new_attr4 got %h want %h", attr_b[4], exp4);
        else pass_cnt++;
    endtask

    initial begin
        req_a = 1'b0; idx_a = '0; attr_in_a = '0;
        req_b = 1'b0; idx_b = '0; attr_in_b = '0;
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        for (int i = 0; i < 16; i++) warl_a[i] = '1;
        warl_a[3] = '0;
        warl_a[3].invert = 1'b1;
        warl_a[3].virt_od_en = 1'b1;
        warl_a[5] = '0;
        warl_a[5].invert = 1'b1;
        for (int i = 0; i < 12; i++) warl_b[i] = '1;
        #2;

        test_reset();
        test_basic();
        tick();
        test_warl_mask();
        test_out_of_range();
        test_back_to_back();
        tick();
        test_reset_mid_release();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
